// File: rtl/psum_serializer.sv
// Row buffer that serializes COL-word psum rows into a one-word-per-cycle valid-only stream
// and drives the downstream accumulator clear at accumulation-group boundaries.
module psum_serializer #(
  parameter int COL   = 8,
  parameter int DEPTH = 4,
  parameter int ACC_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [COL*32-1:0]         in_data,
  input  logic [ACC_W-1:0]          acc_len,
  input  logic                      out_ready,
  output logic [31:0]               sfp_data,
  output logic                      sfp_valid,
  output logic                      sfp_acc_clear,
  output logic                      group_done,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;

  logic [31:0]      mem_q [DEPTH][COL];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [CW-1:0]    col_q, col_d;
  logic [ACC_W-1:0] grp_q, grp_d;
  logic [31:0]      data_q, data_d;
  logic             vld_q, vld_d;
  logic             clr_q, clr_d;
  logic             done_q, done_d;

  logic             push, issue, pop, last_col, grp_end;
  logic [ACC_W-1:0] len_m1;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign count    = count_q;

  assign sfp_data      = data_q;
  assign sfp_valid     = vld_q;
  assign sfp_acc_clear = clr_q;
  assign group_done    = done_q;

  always_comb begin
    push     = in_valid && !full && !flush;
    issue    = !empty && out_ready && !flush;
    last_col = (col_q == CW'(COL-1));
    pop      = issue && last_col;
    // acc_len of 0 behaves as 1, so every word closes its own group
    len_m1   = (acc_len == '0) ? '0 : acc_len - 1'b1;
    grp_end  = (grp_q >= len_m1);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    col_d    = col_q;
    grp_d    = grp_q;
    data_d   = data_q;
    vld_d    = 1'b0;
    clr_d    = 1'b0;
    done_d   = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      col_d    = '0;
      grp_d    = '0;
      clr_d    = 1'b1;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;

      if (issue) begin
        data_d = mem_q[rd_ptr_q][col_q];
        vld_d  = 1'b1;
        col_d  = last_col ? '0 : col_q + 1'b1;
        grp_d  = grp_end ? '0 : grp_q + 1'b1;
        clr_d  = grp_end;
        done_d = grp_end;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int c = 0; c < COL; c++) mem_q[wr_ptr_q][c] <= in_data[32*c +: 32];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      col_q    <= '0;
      grp_q    <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      clr_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      col_q    <= col_d;
      grp_q    <= grp_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      clr_q    <= clr_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_psum_serializer.sv
// Randomized and scenario-driven bench for psum_serializer against a word-queue reference model.
module tb_psum_serializer;

  localparam int COL   = 8;
  localparam int DEPTH = 4;
  localparam int ACC_W = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [COL*32-1:0]      in_data;
  logic [ACC_W-1:0]       acc_len;
  logic                   out_ready;
  logic [31:0]            sfp_data;
  logic                   sfp_valid;
  logic                   sfp_acc_clear;
  logic                   group_done;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;
  logic                   full;

  psum_serializer #(.COL(COL), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .acc_len(acc_len), .out_ready(out_ready), .sfp_data(sfp_data),
    .sfp_valid(sfp_valid), .sfp_acc_clear(sfp_acc_clear), .group_done(group_done),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered words in arrival order plus row/column/group bookkeeping
  int unsigned m_wq[$];
  int          m_rows;
  int          m_col;
  int          m_grp;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wq.delete();
    m_rows = 0;
    m_col  = 0;
    m_grp  = 0;
    m_data = '0;
  endtask

  function automatic logic [COL*32-1:0] seq_row(input int base);
    logic [COL*32-1:0] r;
    for (int c = 0; c < COL; c++) r[32*c +: 32] = 32'(base + c);
    return r;
  endfunction

  function automatic logic [COL*32-1:0] rand_row();
    logic [COL*32-1:0] r;
    for (int c = 0; c < COL; c++) r[32*c +: 32] = $urandom;
    return r;
  endfunction

  task automatic step(input bit v, input logic [COL*32-1:0] row, input bit fl,
                      input bit ordy, input logic [ACC_W-1:0] alen);
    bit e_vld, e_clr, e_done, do_issue, do_push;
    int len;
    @(negedge clk);
    in_valid  = v;
    in_data   = row;
    flush     = fl;
    out_ready = ordy;
    acc_len   = alen;
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_rows != DEPTH));

    e_vld = 0; e_clr = 0; e_done = 0;
    len = (alen == 0) ? 1 : int'(alen);
    if (fl) begin
      m_wq.delete();
      m_rows = 0;
      m_col  = 0;
      m_grp  = 0;
      e_clr  = 1;
    end else begin
      do_issue = (m_rows > 0) && ordy;
      do_push  = v && (m_rows < DEPTH);
      if (do_issue) begin
        m_data = m_wq.pop_front();
        e_vld  = 1;
        m_grp++;
        if (m_grp >= len) begin
          e_clr  = 1;
          e_done = 1;
          m_grp  = 0;
        end
        m_col++;
        if (m_col == COL) begin
          m_col = 0;
          m_rows--;
        end
      end
      if (do_push) begin
        for (int c = 0; c < COL; c++) m_wq.push_back(row[32*c +: 32]);
        m_rows++;
      end
    end

    @(posedge clk);
    #1;
    chk("sfp_valid", 32'(sfp_valid), 32'(e_vld));
    chk("sfp_acc_clear", 32'(sfp_acc_clear), 32'(e_clr));
    chk("group_done", 32'(group_done), 32'(e_done));
    chk("sfp_data", sfp_data, m_data);
    chk("count", 32'(count), 32'(m_rows));
    chk("empty", 32'(empty), 32'(m_rows == 0));
    chk("full", 32'(full), 32'(m_rows == DEPTH));
  endtask

  task automatic idle(input int n, input bit ordy, input logic [ACC_W-1:0] alen);
    for (int i = 0; i < n; i++) step(0, '0, 0, ordy, alen);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(sfp_valid), 32'd0);
    chk({tag, "_clear"}, 32'(sfp_acc_clear), 32'd0);
    chk({tag, "_done"}, 32'(group_done), 32'd0);
    chk({tag, "_data"}, sfp_data, 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    acc_len = 8'd8; out_ready = 1'b1;
    model_reset();
    #12;
    check_reset_state("rst");
    @(negedge clk);
    reset = 1'b1;

    // single row, one group per row
    step(1, seq_row(1), 0, 1, 8);
    idle(10, 1, 8);

    // groups of three crossing a row boundary
    step(1, seq_row(10), 0, 1, 3);
    step(1, seq_row(20), 0, 1, 3);
    idle(18, 1, 3);

    // fill to full under backpressure, fifth row refused, then drain
    for (int r = 0; r < DEPTH + 1; r++) step(1, seq_row(100 + 16*r), 0, 0, 4);
    idle(2, 0, 4);
    idle(36, 1, 4);

    // stall for three cycles after column 2
    step(1, seq_row(200), 0, 1, 5);
    idle(3, 1, 5);
    idle(3, 0, 5);
    idle(10, 1, 5);

    // flush with two rows buffered mid-group, then restart
    step(1, seq_row(300), 0, 0, 6);
    step(1, seq_row(400), 0, 0, 6);
    idle(3, 1, 6);
    step(1, seq_row(500), 1, 1, 6);
    step(1, seq_row(600), 0, 1, 6);
    idle(12, 1, 6);

    // acc_len of zero closes a group on every word
    step(1, seq_row(700), 0, 1, 0);
    idle(10, 1, 0);

    // randomized traffic with occasional flushes and acc_len changes
    begin
      logic [ACC_W-1:0] alen;
      alen = 8'd4;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 49) == 0) alen = ACC_W'($urandom_range(0, 12));
        step($urandom_range(0, 1) == 1, rand_row(), $urandom_range(0, 59) == 0,
             $urandom_range(0, 9) < 7, alen);
      end
    end
    idle(40, 1, 4);

    // asynchronous reset in the middle of a row
    step(1, seq_row(800), 0, 1, 3);
    idle(3, 1, 3);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_state("arst");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(1, seq_row(900), 0, 1, 8);
    idle(10, 1, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
